uart_rx_framed: RTL and testbench
=================================

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
- Parameters, one per line: name, default, meaning.
- Ports, one per line: name, direction, width, meaning.

REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clocks per bit (115200 baud at 50 MHz); legal range 8..16383.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-005 SHALL have port i_clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_rx, input, 1, asynchronous serial line; idles high.
REQ-008 SHALL have port o_rx_byte_rdy, output, 1, one-clock pulse when a frame completes.
REQ-009 SHALL have port o_rx_byte, output, DATA_BITS, received data, LSB-first on the line.
REQ-010 SHALL have port o_parity_err, output, 1, parity mismatch for the last frame.
REQ-011 SHALL have port o_frame_err, output, 1, a stop bit sampled low in the last frame.
REQ-012 SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL pass i_rx through a two-flop synchroniser; both flops reset to 1. All sampling uses the second flop ("rxs").
REQ-014 SHALL size the bit counter at $clog2(CLKS_PER_BIT) bits; it never exceeds CLKS_PER_BIT-1.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE and WAIT_HIGH.
REQ-016 IDLE: on rxs==0, clear the counter and go to START.
REQ-017 START: count to (CLKS_PER_BIT-1)/2.
- rxs==0 at that count: clear the counter, go to DATA.
- rxs==1 at that count: glitch; return to IDLE with no pulse and no error update.
REQ-018 DATA/PARITY/STOP: each bit is decided when the counter reaches CLKS_PER_BIT-1.
- Bit value is the 2-of-3 majority of rxs at counts CLKS_PER_BIT-3, -2 and -1.
- The counter then wraps to 0.
REQ-019 DATA: store bit k in o_rx_byte[k] shift position, k = 0..DATA_BITS-1.
- After bit DATA_BITS-1, go to PARITY if PARITY!=0, else go to STOP.
REQ-020 PARITY: the error condition is:
- odd mode: XOR(data, parity bit) == 0;
- even mode: XOR(data, parity bit) == 1.
REQ-021 STOP: sample STOP_BITS stop bits; any sampled 0 sets the frame error, and remaining stop bits are still timed.
REQ-022 DONE (one clock):
- assert o_rx_byte_rdy;
- update o_rx_byte, o_parity_err and o_frame_err together; all three are valid from this cycle;
- hold these values until the next DONE.
REQ-023 From DONE, go to IDLE if rxs==1, else go to WAIT_HIGH. A line held low (break) SHALL NOT retrigger a frame.
REQ-024 WAIT_HIGH: stay until rxs==1, then go to IDLE.
REQ-025 Data bits SHALL be delivered even when an error flag is set.
REQ-026 Latency:
- o_rx_byte_rdy rises exactly 1 clock after the last stop-bit decision;
- rxs to IDLE re-arm takes at most 1 clock when the line is high.
REQ-027 Any undefined state encoding SHALL recover to IDLE on the next clock.

Reset
REQ-028 i_rst SHALL force, on the next rising edge:
- state IDLE and counter 0;
- synchroniser flops 1;
- o_rx_byte 0, o_rx_byte_rdy 0, o_parity_err 0, o_frame_err 0, o_busy 0.
REQ-029 Reset mid-frame SHALL abort the frame with no o_rx_byte_rdy pulse; reception resumes at the next falling edge after i_rst deasserts.

Verification
REQ-030 Defaults, line frame 0x3F 8N1 at 434 clocks per bit -> one rdy pulse, o_rx_byte=0x3F, both error flags 0, rdy 1 clock after the stop decision.
REQ-031 PARITY=2, DATA_BITS=7, byte 0x55 with parity bit 1 -> o_parity_err=1 and o_rx_byte=0x55; same byte with parity bit 0 -> o_parity_err=0.
REQ-032 Stop bit driven 0, then line held low for 20 bit times -> o_frame_err=1, exactly one rdy pulse; the next valid 0xA5 frame is received correctly with o_frame_err=0.
REQ-033 Low pulse of 100 clocks on an idle line -> no rdy pulse; o_busy returns to 0.
REQ-034 Single-clock high glitch at mid data bit 3 of 0x00 -> o_rx_byte=0x00 (majority rejects the glitch).
REQ-035 i_rst asserted during data bit 4 -> no rdy pulse, all outputs 0; a following 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver: 2-flop synchroniser, 2-of-3 majority bit decisions,
// optional odd/even parity, 1 or 2 stop bits, framing/parity flags latched at frame end.
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic                 o_rx_byte_rdy,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_S0    = CW'(CLKS_PER_BIT - 3);
  localparam logic [CW-1:0] CNT_S1    = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_DONE      = 3'd5,
    S_WAIT_HIGH = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_x;
  logic                 ferr_acc;
  logic                 in_bit, bit_tick, maj, stop_last, par_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rxs     <= rx_meta;
    end
  end

  assign in_bit    = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);
  assign bit_tick  = in_bit && (cnt == CNT_LAST);
  // Two earlier samples plus the live value taken at the decision count
  assign maj       = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
  assign stop_last = (state == S_STOP) && bit_tick && (bit_idx == LAST_STOP);

  always_comb begin
    par_err = 1'b0;
    if (PARITY == 1) par_err = ~par_x;
    else if (PARITY == 2) par_err = par_x;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!rxs) state_nxt = S_START;
      S_START:     if (cnt == CNT_HALF) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:      if (bit_tick && bit_idx == LAST_DATA) state_nxt = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY:    if (bit_tick) state_nxt = S_STOP;
      S_STOP:      if (stop_last) state_nxt = S_DONE;
      S_DONE:      state_nxt = rxs ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rxs) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else begin
      case (state)
        S_START: cnt <= (cnt == CNT_HALF) ? '0 : cnt + 1'b1;
        S_DATA, S_PARITY, S_STOP: cnt <= bit_tick ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      samp     <= 2'b11;
      bit_idx  <= '0;
      shreg    <= '0;
      par_x    <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (in_bit && cnt == CNT_S0) samp[0] <= rxs;
      if (in_bit && cnt == CNT_S1) samp[1] <= rxs;
      case (state)
        S_IDLE: begin
          bit_idx  <= '0;
          par_x    <= 1'b0;
          ferr_acc <= 1'b0;
        end
        S_DATA: if (bit_tick) begin
          shreg   <= {maj, shreg[DATA_BITS-1:1]};
          par_x   <= par_x ^ maj;
          bit_idx <= (bit_idx == LAST_DATA) ? '0 : bit_idx + 4'd1;
        end
        S_PARITY: if (bit_tick) begin
          par_x   <= par_x ^ maj;
          bit_idx <= '0;
        end
        S_STOP: if (bit_tick) begin
          ferr_acc <= ferr_acc | ~maj;
          bit_idx  <= bit_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Results are loaded on the final stop decision so they are valid in the DONE cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rx_byte    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else if (stop_last) begin
      o_rx_byte    <= shreg;
      o_parity_err <= par_err;
      o_frame_err  <= ferr_acc | ~maj;
    end
  end

  assign o_rx_byte_rdy = (state == S_DONE);
  assign o_busy        = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three parameterisations driven with directed and random
// frames; expectations come from a frame-level model of the line protocol.
module tb_uart_rx_framed;

  localparam int CPB [3] = '{434, 16, 8};
  localparam int DB  [3] = '{8, 7, 9};
  localparam int PM  [3] = '{0, 2, 1};
  localparam int SB  [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_line;
  logic [2:0] rdy, perr, ferr, busy;
  logic [7:0] b0;
  logic [6:0] b1;
  logic [8:0] b2;

  int checks = 0, failures = 0;
  int cyc = 0;

  int         pulses    [3] = '{0, 0, 0};
  int         pulse_cyc [3] = '{0, 0, 0};
  logic [8:0] cap_byte  [3];
  logic       cap_perr  [3];
  logic       cap_ferr  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_framed #(.CLKS_PER_BIT(434), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_line[0]), .o_rx_byte_rdy(rdy[0]), .o_rx_byte(b0),
    .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_busy(busy[0]));
  uart_rx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_line[1]), .o_rx_byte_rdy(rdy[1]), .o_rx_byte(b1),
    .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_busy(busy[1]));
  uart_rx_framed #(.CLKS_PER_BIT(8), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_line[2]), .o_rx_byte_rdy(rdy[2]), .o_rx_byte(b2),
    .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_busy(busy[2]));

  // Capture each completion pulse and the result visible in that same cycle
  always @(negedge clk) begin
    if (rdy[0]) begin pulses[0]++; pulse_cyc[0] = cyc; cap_byte[0] = {1'b0, b0}; cap_perr[0] = perr[0]; cap_ferr[0] = ferr[0]; end
    if (rdy[1]) begin pulses[1]++; pulse_cyc[1] = cyc; cap_byte[1] = {2'b0, b1}; cap_perr[1] = perr[1]; cap_ferr[1] = ferr[1]; end
    if (rdy[2]) begin pulses[2]++; pulse_cyc[2] = cyc; cap_byte[2] = b2;         cap_perr[2] = perr[2]; cap_ferr[2] = ferr[2]; end
  end

  function automatic logic [8:0] mask(input int d);
    return 9'((1 << DB[d]) - 1);
  endfunction

  function automatic logic [8:0] live_byte(input int d);
    case (d)
      0:       return {1'b0, b0};
      1:       return {2'b0, b1};
      default: return b2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame onto line d. glitch_at / rst_at name a line-bit index (0 = start bit).
  task automatic send_frame(input int d, input logic [8:0] data, input logic pflip,
                            input logic [1:0] stop_v, input int hold_low, input int glitch_at,
                            input int rst_at, output int t0);
    logic bits[$];
    int   c, ones;
    logic pbit;
    c = CPB[d];
    bits.push_back(1'b0);
    for (int i = 0; i < DB[d]; i++) bits.push_back(data[i]);
    if (PM[d] != 0) begin
      ones = $countones(data & mask(d));
      pbit = (PM[d] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      bits.push_back(pbit ^ pflip);
    end
    for (int s = 0; s < SB[d]; s++) bits.push_back(stop_v[s]);
    @(posedge clk); #1;
    t0 = cyc;
    for (int b = 0; b < bits.size(); b++) begin
      rx_line[d] = bits[b];
      for (int k = 0; k < c; k++) begin
        if (b == rst_at && k == c / 2) begin
          rst = 1'b1;
          rx_line[d] = 1'b1;
          repeat (3) @(posedge clk);
          #1 rst = 1'b0;
          return;
        end
        if (b == glitch_at && k == c / 2) rx_line[d] = 1'b1;
        else if (b == glitch_at && k == c / 2 + 1) rx_line[d] = bits[b];
        @(posedge clk); #1;
      end
    end
    if (hold_low > 0) begin
      rx_line[d] = 1'b0;
      repeat (hold_low * c) @(posedge clk);
      #1;
    end
    rx_line[d] = 1'b1;
  endtask

  task automatic run_check(input int d, input logic [8:0] data, input logic pflip,
                           input logic [1:0] stop_v, input int hold_low, input int glitch_at,
                           input logic [8:0] exp_byte, input string tag);
    int   pre, t0, n, off, lo, hi;
    logic eperr, eferr;
    pre = pulses[d];
    send_frame(d, data, pflip, stop_v, hold_low, glitch_at, -1, t0);
    repeat (8) @(posedge clk);
    #1;
    n     = 1 + DB[d] + ((PM[d] != 0) ? 1 : 0) + SB[d];
    eperr = (PM[d] != 0) && pflip;
    eferr = (SB[d] == 1) ? ~stop_v[0] : ~(stop_v[0] & stop_v[1]);
    off   = pulse_cyc[d] - t0;
    lo    = (n - 1) * CPB[d] + CPB[d] / 2;
    hi    = n * CPB[d] + 4;
    chk($sformatf("%s pulses", tag), pulses[d], pre + 1);
    chk($sformatf("%s byte", tag), cap_byte[d], exp_byte);
    chk($sformatf("%s parity_err", tag), cap_perr[d], eperr);
    chk($sformatf("%s frame_err", tag), cap_ferr[d], eferr);
    chk($sformatf("%s rdy_timing off=%0d", tag, off), (off >= lo && off <= hi), 1);
    chk($sformatf("%s held_byte", tag), live_byte(d), exp_byte);
    chk($sformatf("%s busy", tag), busy[d], 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d byte", tag, d), live_byte(d), 9'h0);
      chk($sformatf("%s d%0d rdy", tag, d), rdy[d], 1'b0);
      chk($sformatf("%s d%0d perr", tag, d), perr[d], 1'b0);
      chk($sformatf("%s d%0d ferr", tag, d), ferr[d], 1'b0);
      chk($sformatf("%s d%0d busy", tag, d), busy[d], 1'b0);
    end
  endtask

  initial begin
    logic [8:0] data;
    logic [1:0] sv;
    logic       pf;
    int         pre, t0;

    rst     = 1'b1;
    rx_line = 3'b111;
    repeat (4) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    run_check(0, 9'h03F, 1'b0, 2'b11, 0, -1, 9'h03F, "8n1_3f");

    run_check(1, 9'h055, 1'b1, 2'b11, 0, -1, 9'h055, "even_55_p1");
    chk("even_55_p1 perr_const", cap_perr[1], 1'b1);
    run_check(1, 9'h055, 1'b0, 2'b11, 0, -1, 9'h055, "even_55_p0");
    chk("even_55_p0 perr_const", cap_perr[1], 1'b0);

    data = 9'($urandom_range(0, 255));
    run_check(0, data, 1'b0, 2'b00, 20, -1, data, "break");
    run_check(0, 9'h0A5, 1'b0, 2'b11, 0, -1, 9'h0A5, "after_break_a5");

    pre = pulses[0];
    @(posedge clk); #1;
    rx_line[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("short_low busy_mid", busy[0], 1'b1);
    repeat (50) @(posedge clk);
    #1 rx_line[0] = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    chk("short_low pulses", pulses[0], pre);
    chk("short_low busy_end", busy[0], 1'b0);

    run_check(0, 9'h000, 1'b0, 2'b11, 0, 4, 9'h000, "glitch_bit3");

    for (int i = 0; i < 12; i++) begin
      data = 9'($urandom_range(0, 127));
      pf   = 1'($urandom_range(0, 1));
      sv   = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      run_check(1, data, pf, sv, 0, -1, data, $sformatf("rnd1_%0d", i));
    end
    for (int i = 0; i < 12; i++) begin
      data = 9'($urandom_range(0, 511));
      pf   = 1'($urandom_range(0, 1));
      sv   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      run_check(2, data, pf, sv, 0, -1, data, $sformatf("rnd2_%0d", i));
    end
    data = 9'($urandom_range(0, 255)) | 9'h001;
    run_check(0, data, 1'b0, 2'b11, 0, -1, data, "rnd0");

    pre = pulses[0];
    data = 9'($urandom_range(0, 255));
    send_frame(0, data, 1'b0, 2'b11, 0, -1, 5, t0);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid pulses", pulses[0], pre);
    check_cleared("rst_mid");
    run_check(0, 9'h0C3, 1'b0, 2'b11, 0, -1, 9'h0C3, "after_rst_c3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
